// File: rtl/apb_mem_slave_if.sv
// APB completer bus bundle for apb_mem_slave.
// pstrb_i exists only when APB_PSTRB_EN is defined.
interface apb_mem_slave_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
);
   logic                  psel_i;
   logic                  penable_i;
   logic [ADDR_W-1:0]     paddr_i;
   logic                  pwrite_i;
   logic [DATA_W-1:0]     pwdata_i;
`ifdef APB_PSTRB_EN
   logic [DATA_W/8-1:0]   pstrb_i;
`endif
   logic [DATA_W-1:0]     prdata_o;
   logic                  pready_o;
   logic                  pslverr_o;

   modport master (
      output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
`ifdef APB_PSTRB_EN
      output pstrb_i,
`endif
      input  prdata_o, pready_o, pslverr_o
   );

   modport slave (
      input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
`ifdef APB_PSTRB_EN
      input  pstrb_i,
`endif
      output prdata_o, pready_o, pslverr_o
   );
endinterface

// File: rtl/apb_mem_slave.sv
// Parametrised APB completer backed by a word-addressed register-file memory.
// Optional byte-strobed writes are enabled by defining APB_PSTRB_EN.
module apb_mem_slave #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic            clk,
   input  logic            reset,
   apb_mem_slave_if.slave  bus
);
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit          FULL_RANGE = (64'(DEPTH) >= (64'(1) << ADDR_W));

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pready;
   logic              in_range;
   logic              strb_err;
   logic [STRB_W-1:0] wr_strb;
   logic              done;
   logic              we;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Setup enters ACCESS with the wait counter loaded; deselect aborts.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.psel_i && !bus.penable_i) begin
               state_d = ST_ACCESS;
               cnt_d   = CNT_W'(WAIT_CYCLES);
            end
         end
         ST_ACCESS: begin
            if (!bus.psel_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (bus.penable_i) begin
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
               else             state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign pready = (state_q == ST_ACCESS) && (cnt_q == '0);
   assign done   = pready && bus.psel_i && bus.penable_i;
   assign idx    = IDX_W'(bus.paddr_i);

   generate
      if (FULL_RANGE) begin : g_full
         assign in_range = 1'b1;
      end else begin : g_part
         assign in_range = (bus.paddr_i < ADDR_W'(DEPTH));
      end
   endgenerate

`ifdef APB_PSTRB_EN
   assign strb_err = !bus.pwrite_i && (bus.pstrb_i != '0);
   assign wr_strb  = bus.pstrb_i;
`else
   assign strb_err = 1'b0;
   assign wr_strb  = '1;
`endif

   assign we = done && bus.pwrite_i && in_range;

   // Storage is deliberately unreset so contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < int'(STRB_W); b++) begin
            if (wr_strb[b]) mem[idx][8*b +: 8] <= bus.pwdata_i[8*b +: 8];
         end
      end
   end

   assign bus.pready_o  = pready;
   assign bus.pslverr_o = pready && (!in_range || strb_err);
   assign bus.prdata_o  = (pready && !bus.pwrite_i && in_range && !strb_err)
                          ? mem[idx] : '0;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: one zero-wait full-depth instance and
// one two-wait-state 512-word instance, compared against an array reference model.
module tb_apb_mem_slave;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] ref_mem [2][1024];

   always #5 clk = ~clk;

   apb_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   apb_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   apb_mem_slave #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0));
   apb_mem_slave #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(512), .WAIT_CYCLES(2)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1));

   function automatic int depth_of(input int d);
      return (d == 0) ? 1024 : 512;
   endfunction

   function automatic int wait_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic logic rdy(input int d);
      return (d == 0) ? bus0.pready_o : bus1.pready_o;
   endfunction

   function automatic logic serr(input int d);
      return (d == 0) ? bus0.pslverr_o : bus1.pslverr_o;
   endfunction

   function automatic logic [31:0] rdat(input int d);
      return (d == 0) ? bus0.prdata_o : bus1.prdata_o;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_sel(input int d, input logic sel, input logic en);
      if (d == 0) begin bus0.psel_i = sel; bus0.penable_i = en; end
      else        begin bus1.psel_i = sel; bus1.penable_i = en; end
   endtask

   task automatic set_fields(input logic wr, input logic [9:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
      bus0.pwrite_i = wr; bus0.paddr_i = addr; bus0.pwdata_i = data;
      bus1.pwrite_i = wr; bus1.paddr_i = addr; bus1.pwdata_i = data;
`ifdef APB_PSTRB_EN
      bus0.pstrb_i = strb; bus1.pstrb_i = strb;
`else
      if (strb == 4'hx) bus0.pwrite_i = wr;
`endif
   endtask

   // One full transfer, entered and left #1 after a rising edge.
   task automatic xfer(input int d, input logic wr, input logic [9:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       output logic [31:0] rd, output logic err, output int cyc);
      logic got;
      set_fields(wr, addr, data, strb);
      set_sel(d, 1'b1, 1'b0);
      cyc = 1;
      got = 1'b0;
      @(posedge clk); #1;
      set_sel(d, 1'b1, 1'b1);
      for (int i = 0; i < 40; i++) begin
         cyc++;
         if (rdy(d)) begin got = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (!got) check("pready_timeout", 32'(got), 32'd1);
      rd  = rdat(d);
      err = serr(d);
      @(posedge clk); #1;
      set_sel(d, 1'b0, 1'b0);
   endtask

   task automatic op_write(input int d, input logic [9:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string tag);
      logic [31:0] rd;
      logic        err;
      int          cyc;
      bit          ok;
      xfer(d, 1'b1, addr, data, strb, rd, err, cyc);
      ok = (int'(addr) < depth_of(d));
      check({tag, "_err"}, 32'(err), 32'(!ok));
      check({tag, "_cyc"}, 32'(cyc), 32'(2 + wait_of(d)));
      if (ok) begin
`ifdef APB_PSTRB_EN
         for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[d][addr][8*b +: 8] = data[8*b +: 8];
`else
         ref_mem[d][addr] = data;
`endif
      end
   endtask

   task automatic op_read(input int d, input logic [9:0] addr, input logic [3:0] strb,
                          input string tag);
      logic [31:0] rd;
      logic        err;
      int          cyc;
      bit          bad;
      xfer(d, 1'b0, addr, 32'h0, strb, rd, err, cyc);
      bad = (int'(addr) >= depth_of(d));
`ifdef APB_PSTRB_EN
      if (strb != 4'h0) bad = 1'b1;
`endif
      check({tag, "_err"}, 32'(err), 32'(bad));
      check({tag, "_data"}, rd, bad ? 32'h0 : ref_mem[d][addr]);
      check({tag, "_cyc"}, 32'(cyc), 32'(2 + wait_of(d)));
   endtask

   initial begin
      logic [9:0] addrs [10];
      reset = 1'b1;
      set_sel(0, 1'b0, 1'b0);
      set_sel(1, 1'b0, 1'b0);
      set_fields(1'b0, 10'h0, 32'h0, 4'h0);

      // Reset held two cycles: all outputs quiet.
      repeat (2) @(posedge clk);
      #1;
      check("rst_pready0", 32'(bus0.pready_o), 32'd0);
      check("rst_prdata0", bus0.prdata_o, 32'h0);
      check("rst_pslverr0", 32'(bus0.pslverr_o), 32'd0);
      check("rst_pready1", 32'(bus1.pready_o), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Basic zero-wait transfers and write-then-read of the same word.
      op_write(0, 10'h155, 32'hDEADBEEF, 4'hF, "wr155");
      op_read (0, 10'h155, 4'h0, "rd155");
      op_write(0, 10'h010, 32'h0BADF00D, 4'hF, "wr010");
      op_read (0, 10'h010, 4'h0, "rd010");
      op_write(0, 10'h3FF, 32'h5A5AA5A5, 4'hF, "wr3ff");
      op_read (0, 10'h3FF, 4'h0, "rd3ff");

      // Reset in the first access cycle of a write: pready drops, no write.
      set_fields(1'b1, 10'h010, 32'h12345678, 4'hF);
      set_sel(0, 1'b1, 1'b0);
      @(posedge clk); #1;
      set_sel(0, 1'b1, 1'b1);
      check("mid_pready_pre", 32'(bus0.pready_o), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_pready_drop", 32'(bus0.pready_o), 32'd0);
      check("mid_pslverr", 32'(bus0.pslverr_o), 32'd0);
      @(posedge clk); #1;
      set_sel(0, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      op_read(0, 10'h010, 4'h0, "rd010_after_rst");

      // Wait states and abort on the two-wait instance.
      op_write(1, 10'h020, 32'h13579BDF, 4'hF, "w2_wr020");
      op_read (1, 10'h020, 4'h0, "w2_rd020");
      set_fields(1'b1, 10'h020, 32'hCAFEF00D, 4'hF);
      set_sel(1, 1'b1, 1'b0);
      @(posedge clk); #1;
      set_sel(1, 1'b1, 1'b1);
      check("abort_acc1_pready", 32'(bus1.pready_o), 32'd0);
      @(posedge clk); #1;
      check("abort_acc2_pready", 32'(bus1.pready_o), 32'd0);
      set_sel(1, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("abort_idle_pready", 32'(bus1.pready_o), 32'd0);
      op_read(1, 10'h020, 4'h0, "abort_rd020");

      // Range boundary on the 512-word instance.
      op_write(1, 10'h200, 32'h0000AAAA, 4'hF, "oor_wr200");
      op_read (1, 10'h200, 4'h0, "oor_rd200");
      op_write(1, 10'h1FF, 32'h600DCAFE, 4'hF, "in_wr1ff");
      op_read (1, 10'h1FF, 4'h0, "in_rd1ff");

`ifdef APB_PSTRB_EN
      // Byte strobes.
      op_write(0, 10'h0A0, 32'h11223344, 4'hF, "st_full");
      op_write(0, 10'h0A0, 32'hAABBCCDD, 4'b0101, "st_part");
      op_read (0, 10'h0A0, 4'h0, "st_rd");
      op_write(0, 10'h0A0, 32'hFFFFFFFF, 4'h0, "st_none");
      op_read (0, 10'h0A0, 4'h0, "st_rd2");
      op_read (0, 10'h0A0, 4'h1, "st_rd_strb");
      op_write(1, 10'h0A1, 32'h01020304, 4'b1010, "st1_part");
      op_read (1, 10'h0A1, 4'h0, "st1_rd");
`endif

      // Random back-to-back stress on both instances.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 10; i++) begin
            addrs[i] = 10'($urandom_range(0, 1023));
            op_write(d, addrs[i], 32'($urandom_range(0, 65535)), 4'hF, "rnd_wr");
         end
         for (int i = 0; i < 10; i++) op_read(d, addrs[i], 4'h0, "rnd_rd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
